// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that shares one MUX4 4:1 datapath
// among four requesters. It drives the mux select and a one-hot grant, and it
// limits each tenure to HOLD_MAX cycles while another requester is waiting.
// All outputs are registered, so there is no combinational path from req.
//
// Optional build macro: MUX4_ARB_LOCK_EN
//   When it is defined, the block gains a 'lock' input. While the block is
//   busy and lock is high, forced rotation is suppressed. A drop of the
//   owner's request still releases the grant.
//   When it is undefined, the block has no lock port and rotation is
//   governed by HOLD_MAX alone.
//
// The companion module mux4_rr_arbiter_chk holds the output invariants as
// concurrent assertions. It is meant to be instantiated next to the arbiter.

module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
`ifdef MUX4_ARB_LOCK_EN
    input  logic       lock,
`endif
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       switch
);

    // Reject a tenure limit that the 4-bit hold counter cannot represent.
    if ((HOLD_MAX < 1) || (HOLD_MAX > 15)) begin : g_bad_hold_max
        $error("mux4_rr_arbiter: HOLD_MAX must be in 1..15");
    end

    localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Map a requester index to its one-hot grant pattern.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] res;
        case (idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // Find the first set bit of 'mask'. The search visits base+1, base+2,
    // and so on, and it wraps 3->0. Because 'base' itself is visited last,
    // the previous owner has the lowest priority. The caller guarantees that
    // mask is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] base);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = base;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = base + 2'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    // Registered state and outputs.
    state_t     r_state;
    logic [3:0] r_hold_cnt;
    logic [1:0] r_last;
    logic [3:0] r_grant;
    logic [1:0] r_sel;
    logic       r_busy;
    logic       r_switch;

    // Next-state values.
    state_t     w_state_nxt;
    logic [3:0] w_hold_nxt;
    logic [1:0] w_last_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_sel_nxt;
    logic       w_busy_nxt;
    logic       w_switch_nxt;

    // Arbitration helpers.
    logic [3:0] w_others;     // pending requests from anyone but the owner
    logic       w_take;       // a new owner takes the grant next cycle
    logic [1:0] w_pick;       // index of that new owner
    logic       w_lock;       // suppresses forced rotation while high
    logic       w_hold_full;  // tenure has reached HOLD_MAX

`ifdef MUX4_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_others    = req & ~onehot4(r_sel);
    assign w_hold_full = (r_hold_cnt == HOLD_MAX_C);

    // Next-state and next-output decision: pick the owner, rotate, or release.
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_last_nxt   = r_last;
        w_grant_nxt  = r_grant;
        w_sel_nxt    = r_sel;
        w_busy_nxt   = r_busy;
        w_switch_nxt = 1'b0;
        w_take       = 1'b0;
        w_pick       = 2'b00;

        case (r_state)
            ST_IDLE: begin
                // Search from the last owner + 1. Reset sets last to 3, so
                // requester 0 has first priority.
                if (req != 4'b0000) begin
                    w_take = 1'b1;
                    w_pick = rr_pick(req, r_last);
                end else begin
                    w_grant_nxt = 4'b0000;
                    w_busy_nxt  = 1'b0;
                end
            end

            ST_BUSY: begin
                if (!req[r_sel]) begin
                    if (w_others != 4'b0000) begin
                        // The owner let go and someone else is waiting.
                        w_take = 1'b1;
                        w_pick = rr_pick(w_others, r_sel);
                    end else begin
                        // Nobody left. Go idle; sel keeps the last owner.
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = 4'b0000;
                        w_busy_nxt  = 1'b0;
                        w_hold_nxt  = 4'b0000;
                    end
                end else if (w_hold_full && (w_others != 4'b0000) && !w_lock) begin
                    // Tenure is used up and others wait: force a rotation.
                    w_take = 1'b1;
                    w_pick = rr_pick(w_others, r_sel);
                end else begin
                    // Keep the grant. The counter saturates, so a lone
                    // requester can hold the grant indefinitely.
                    if (r_hold_cnt < HOLD_MAX_C) begin
                        w_hold_nxt = r_hold_cnt + 4'd1;
                    end else begin
                        w_hold_nxt = HOLD_MAX_C;
                    end
                end
            end

            default: begin
                // Recover from an unreachable encoding by dropping to idle.
                w_state_nxt = ST_IDLE;
                w_grant_nxt = 4'b0000;
                w_busy_nxt  = 1'b0;
                w_hold_nxt  = 4'b0000;
            end
        endcase

        // Common hand-over: the grant moves to w_pick on the next cycle.
        if (w_take) begin
            w_state_nxt  = ST_BUSY;
            w_grant_nxt  = onehot4(w_pick);
            w_sel_nxt    = w_pick;
            w_busy_nxt   = 1'b1;
            w_switch_nxt = 1'b1;
            w_hold_nxt   = 4'd1;
            w_last_nxt   = w_pick;
        end else begin
            w_last_nxt   = w_last_nxt;
        end
    end

    // State and output registers. Synchronous reset takes precedence.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_last     <= 2'd3;
            r_grant    <= 4'b0000;
            r_sel      <= 2'b00;
            r_busy     <= 1'b0;
            r_switch   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_last     <= w_last_nxt;
            r_grant    <= w_grant_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_switch   <= w_switch_nxt;
        end
    end

    assign grant  = r_grant;
    assign sel    = r_sel;
    assign busy   = r_busy;
    assign switch = r_switch;

endmodule

// mux4_rr_arbiter_chk: output invariants of mux4_rr_arbiter. The grant is
// one-hot or zero, busy matches a non-zero grant, and a busy grant matches
// sel.
module mux4_rr_arbiter_chk (
    input logic       clk,
    input logic       reset,
    input logic [3:0] grant,
    input logic [1:0] sel,
    input logic       busy,
    input logic       switch
);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant));

    a_busy_iff_grant: assert property (@(posedge clk) disable iff (reset)
        busy == (grant != 4'b0000));

    a_grant_matches_sel: assert property (@(posedge clk) disable iff (reset)
        busy |-> (grant == (4'b0001 << sel)));

    a_switch_only_busy: assert property (@(posedge clk) disable iff (reset)
        switch |-> busy);

endmodule
